// File: rtl/bus_timer_responder_pkg.sv
// Shared encodings for the bus timer responder: bus transfer types,
// protection bits, register offsets and CTRL/STATUS bit positions.
package bus_timer_responder_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE = 2'b00,
        TRANS_BUSY = 2'b01,
        TRANS_NSEQ = 2'b10,
        TRANS_SEQ  = 2'b11
    } trans_e;

    localparam int PROT_DATA_BIT = 0;
    localparam int PROT_PRIV_BIT = 1;

    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_LOAD     = 3'd1,
        OFF_VALUE    = 3'd2,
        OFF_STATUS   = 3'd3,
        OFF_PRESCALE = 3'd4
    } reg_off_e;

    localparam int WINDOW_WORDS = 8;

    localparam int CTRL_EN_BIT        = 0;
    localparam int CTRL_PERIODIC_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT    = 2;
    localparam int STATUS_EXPIRED_BIT = 0;

    // Configuration registers may only be written from privileged mode.
    function automatic logic needsPriv(input logic [2:0] offset);
        return (offset == OFF_CTRL) || (offset == OFF_LOAD) || (offset == OFF_PRESCALE);
    endfunction

endpackage

// File: rtl/bus_timer_responder_prescaler.sv
// Prescale counter: counts while enabled and emits a one-cycle tick each
// time the count reaches the programmed prescale value.
module timer_prescaler
    import bus_timer_responder_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      n_reset,
    input  logic                      en,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] cnt_q;
    logic [PRESCALE_WIDTH-1:0] cnt_d;

    assign tick = en && (cnt_q == prescale);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped down-counting timer answering bus accesses with one-cycle
// registered latency, reporting illegal accesses on abort.
module bus_timer_responder
    import bus_timer_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2000,
    parameter int          PRESCALE_WIDTH = 16
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        write,
    input  logic        size,
    input  logic [1:0]  prot,
    input  logic [1:0]  trans,
    output logic [31:0] rdata,
    output logic        abort,
    output logic        sel,
    output logic        irq
);

    logic [2:0]                ctrl_q, ctrl_d;
    logic [31:0]               load_q, load_d;
    logic [31:0]               value_q, value_d;
    logic                      expired_q, expired_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      abort_q, abort_d;
    logic                      sel_q, sel_d;
    logic                      irq_q, irq_d;

    logic [31:0] winOffset;
    logic [2:0]  offset;
    logic        hit;
    logic        accessErr;
    logic        wrOk;
    logic        tick;
    logic        tickTakesEffect;
    logic        prescaleClear;
    logic [31:0] readValue;

    assign winOffset = addr - BASE_ADDR;
    assign offset    = winOffset[2:0];
    assign hit       = ((trans == TRANS_NSEQ) || (trans == TRANS_SEQ))
                       && (winOffset < 32'(WINDOW_WORDS));

    always_comb begin
        accessErr = (offset > OFF_PRESCALE)
                    || !size
                    || !prot[PROT_DATA_BIT]
                    || (write && (offset == OFF_VALUE))
                    || (write && needsPriv(offset) && !prot[PROT_PRIV_BIT]);
    end

    assign wrOk = hit && write && !accessErr;

    always_comb begin
        readValue = '0;
        case (offset)
            OFF_CTRL:     readValue = {29'd0, ctrl_q};
            OFF_LOAD:     readValue = load_q;
            OFF_VALUE:    readValue = value_q;
            OFF_STATUS:   readValue = {31'd0, expired_q};
            OFF_PRESCALE: readValue = {{(32-PRESCALE_WIDTH){1'b0}}, prescale_q};
            default:      readValue = '0;
        endcase
    end

    // A LOAD write, or a CTRL write that stops the timer, consumes a coincident tick.
    assign tickTakesEffect = tick
                             && !(wrOk && (offset == OFF_LOAD))
                             && !(wrOk && (offset == OFF_CTRL) && !wdata[CTRL_EN_BIT]);

    assign prescaleClear = wrOk && ((offset == OFF_LOAD)
                           || ((offset == OFF_CTRL) && wdata[CTRL_EN_BIT] && !ctrl_q[CTRL_EN_BIT]));

    always_comb begin
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        value_d    = value_q;
        expired_d  = expired_q;
        prescale_d = prescale_q;

        if (wrOk && (offset == OFF_STATUS) && wdata[STATUS_EXPIRED_BIT]) begin
            expired_d = 1'b0;
        end

        if (tickTakesEffect) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[CTRL_PERIODIC_BIT]) begin
                    value_d = load_q;
                end else begin
                    ctrl_d[CTRL_EN_BIT] = 1'b0;
                end
            end
        end

        if (wrOk) begin
            case (offset)
                OFF_CTRL:     ctrl_d = wdata[2:0];
                OFF_LOAD: begin
                    load_d  = wdata;
                    value_d = wdata;
                end
                OFF_PRESCALE: prescale_d = wdata[PRESCALE_WIDTH-1:0];
                default:      ;
            endcase
        end
    end

    always_comb begin
        sel_d   = hit;
        abort_d = hit && accessErr;
        rdata_d = rdata_q;
        if (hit) begin
            rdata_d = (accessErr || write) ? 32'd0 : readValue;
        end
        irq_d = expired_q && ctrl_q[CTRL_IRQ_EN_BIT];
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            value_q    <= '0;
            expired_q  <= 1'b0;
            prescale_q <= '0;
            rdata_q    <= '0;
            abort_q    <= 1'b0;
            sel_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            value_q    <= value_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
            rdata_q    <= rdata_d;
            abort_q    <= abort_d;
            sel_q      <= sel_d;
            irq_q      <= irq_d;
        end
    end

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .n_reset  (n_reset),
        .en       (ctrl_q[CTRL_EN_BIT]),
        .clear    (prescaleClear),
        .prescale (prescale_q),
        .tick     (tick)
    );

    assign rdata = rdata_q;
    assign abort = abort_q;
    assign sel   = sel_q;
    assign irq   = irq_q;

endmodule
